// File: rtl/system_memory_v4.sv
// Generation memory register: parallel grid load, serial shift-in, and
// rotating serial readout with fixed mode priority RUN > LOAD > OUTPUT > hold.
module system_memory_v4 #(
    parameter int DATA_SIZE = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [DATA_SIZE-1:0] GRID_IN,
    input  logic                 SERIAL_IN,
    input  logic                 LOAD_MODE,
    input  logic                 RUN_MODE,
    input  logic                 OUTPUT_MODE,
    output logic [DATA_SIZE-1:0] SYSTEM_MEM_OUT,
    output logic                 SERIAL_OUT
);

    logic [DATA_SIZE-1:0] mem;
    logic                 sout;

    // SOUT is only ever nonzero on an edge where OUTPUT actually wins priority.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mem  <= '0;
            sout <= 1'b0;
        end else if (RUN_MODE) begin
            mem  <= GRID_IN;
            sout <= 1'b0;
        end else if (LOAD_MODE) begin
            mem  <= {mem[DATA_SIZE-2:0], SERIAL_IN};
            sout <= 1'b0;
        end else if (OUTPUT_MODE) begin
            mem  <= {mem[DATA_SIZE-2:0], mem[DATA_SIZE-1]};
            sout <= mem[DATA_SIZE-1];
        end else begin
            sout <= 1'b0;
        end
    end

    assign SYSTEM_MEM_OUT = mem;
    assign SERIAL_OUT     = sout;

endmodule

// File: tb/tb_system_memory_v4.sv
// Self-checking bench for system_memory_v4 (DATA_SIZE=5): directed scenarios
// plus randomized mode/data traffic against an arithmetic reference model.
module tb_system_memory_v4;

    localparam int N   = 5;
    localparam int MOD = 1 << N;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [N-1:0] GRID_IN;
    logic         SERIAL_IN;
    logic         LOAD_MODE;
    logic         RUN_MODE;
    logic         OUTPUT_MODE;
    logic [N-1:0] SYSTEM_MEM_OUT;
    logic         SERIAL_OUT;

    int compared   = 0;
    int mismatched = 0;
    int model_mem  = 0;
    int model_sout = 0;

    system_memory_v4 #(.DATA_SIZE(N)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .GRID_IN        (GRID_IN),
        .SERIAL_IN      (SERIAL_IN),
        .LOAD_MODE      (LOAD_MODE),
        .RUN_MODE       (RUN_MODE),
        .OUTPUT_MODE    (OUTPUT_MODE),
        .SYSTEM_MEM_OUT (SYSTEM_MEM_OUT),
        .SERIAL_OUT     (SERIAL_OUT)
    );

    always #5 CLK = ~CLK;

    // Drives one edge worth of inputs and advances the model by plain arithmetic:
    // shift-left = x*2 mod 2^N, MSB = x / 2^(N-1).
    task automatic cycle(input bit run, input bit load, input bit outm,
                         input int grid, input bit sin);
        int g;
        g = grid % MOD;
        RUN_MODE    = run;
        LOAD_MODE   = load;
        OUTPUT_MODE = outm;
        GRID_IN     = g[N-1:0];
        SERIAL_IN   = sin;
        @(posedge CLK);
        #1;
        if (run) begin
            model_mem  = g;
            model_sout = 0;
        end else if (load) begin
            model_mem  = (model_mem * 2 + int'(sin)) % MOD;
            model_sout = 0;
        end else if (outm) begin
            model_sout = model_mem / (MOD / 2);
            model_mem  = (model_mem * 2) % MOD + model_sout;
        end else begin
            model_sout = 0;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        RUN_MODE = 0; LOAD_MODE = 0; OUTPUT_MODE = 0; GRID_IN = '0; SERIAL_IN = 0;
        #1;
        compared++;
        if (SYSTEM_MEM_OUT !== 5'b00000 || SERIAL_OUT !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: got mem=%b sout=%b expected mem=00000 sout=0", SYSTEM_MEM_OUT, SERIAL_OUT);
        end
        #2 RESET = 1'b1;
        model_mem = 0; model_sout = 0;
    endtask

    task automatic test_hold_after_reset();
        cycle(0, 0, 0, 5'b11001, 1);
        compared++;
        if (SYSTEM_MEM_OUT !== 5'b00000 || SERIAL_OUT !== 1'b0) begin
            mismatched++;
            $display("FAIL hold_idle: got mem=%b sout=%b expected mem=00000 sout=0", SYSTEM_MEM_OUT, SERIAL_OUT);
        end
    endtask

    task automatic test_load();
        bit bits [4] = '{1, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 0, bits[i]);
            compared++;
            if (SERIAL_OUT !== 1'b0) begin
                mismatched++;
                $display("FAIL load_sout[%0d]: got %b expected 0", i, SERIAL_OUT);
            end
            if (i == 0) begin
                compared++;
                if (SYSTEM_MEM_OUT !== 5'b00001) begin
                    mismatched++;
                    $display("FAIL load_first: got %b expected 00001", SYSTEM_MEM_OUT);
                end
            end
        end
        compared++;
        if (SYSTEM_MEM_OUT !== 5'b01001) begin
            mismatched++;
            $display("FAIL load_fourth: got %b expected 01001", SYSTEM_MEM_OUT);
        end
    endtask

    task automatic test_run_hold_reset();
        cycle(1, 1, 0, 5'b00110, 1);
        compared++;
        if (SYSTEM_MEM_OUT !== 5'b00110) begin
            mismatched++;
            $display("FAIL run_over_load: got %b expected 00110", SYSTEM_MEM_OUT);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 0, 5'b11111, 1);
            compared++;
            if (SYSTEM_MEM_OUT !== 5'b00110 || SERIAL_OUT !== 1'b0) begin
                mismatched++;
                $display("FAIL hold[%0d]: got mem=%b sout=%b expected mem=00110 sout=0", i, SYSTEM_MEM_OUT, SERIAL_OUT);
            end
        end
        RESET = 1'b0;
        #1;
        compared++;
        if (SYSTEM_MEM_OUT !== 5'b00000) begin
            mismatched++;
            $display("FAIL async_reset_pulse: got %b expected 00000", SYSTEM_MEM_OUT);
        end
        RESET = 1'b1;
        model_mem = 0; model_sout = 0;
    endtask

    task automatic test_output_rotation();
        logic [N-1:0] exp_mem [5] = '{5'b11010, 5'b10101, 5'b01011, 5'b10110, 5'b01101};
        logic         exp_out [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        cycle(1, 0, 0, 5'b01101, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 0, 0);
            compared++;
            if (SYSTEM_MEM_OUT !== exp_mem[i] || SERIAL_OUT !== exp_out[i]) begin
                mismatched++;
                $display("FAIL rotate[%0d]: got mem=%b sout=%b expected mem=%b sout=%b",
                         i, SYSTEM_MEM_OUT, SERIAL_OUT, exp_mem[i], exp_out[i]);
            end
        end
    endtask

    task automatic test_precedence();
        RESET = 1'b0;
        #1 RESET = 1'b1;
        model_mem = 0; model_sout = 0;
        cycle(0, 1, 1, 0, 1);
        compared++;
        if (SYSTEM_MEM_OUT !== 5'b00001 || SERIAL_OUT !== 1'b0) begin
            mismatched++;
            $display("FAIL load_over_output: got mem=%b sout=%b expected mem=00001 sout=0", SYSTEM_MEM_OUT, SERIAL_OUT);
        end
        cycle(1, 1, 0, 5'b11011, 0);
        compared++;
        if (SYSTEM_MEM_OUT !== 5'b11011) begin
            mismatched++;
            $display("FAIL run_over_load2: got %b expected 11011", SYSTEM_MEM_OUT);
        end
        cycle(1, 0, 1, 5'b00110, 0);
        compared++;
        if (SYSTEM_MEM_OUT !== 5'b00110 || SERIAL_OUT !== 1'b0) begin
            mismatched++;
            $display("FAIL run_over_output: got mem=%b sout=%b expected mem=00110 sout=0", SYSTEM_MEM_OUT, SERIAL_OUT);
        end
    endtask

    task automatic test_reset_mid_output();
        cycle(1, 0, 0, 5'b10110, 0);
        cycle(0, 0, 1, 0, 0);
        compared++;
        if (SERIAL_OUT !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_output_pre: got sout=%b expected 1", SERIAL_OUT);
        end
        RESET = 1'b0;
        #1;
        compared++;
        if (SYSTEM_MEM_OUT !== 5'b00000 || SERIAL_OUT !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_output_reset: got mem=%b sout=%b expected mem=00000 sout=0", SYSTEM_MEM_OUT, SERIAL_OUT);
        end
        RESET = 1'b1;
        model_mem = 0; model_sout = 0;
        cycle(0, 1, 0, 0, 1);
        compared++;
        if (SYSTEM_MEM_OUT !== 5'b00001) begin
            mismatched++;
            $display("FAIL post_reset_edge: got %b expected 00001", SYSTEM_MEM_OUT);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                RESET = 1'b0;
                #1;
                model_mem = 0; model_sout = 0;
                RESET = 1'b1;
            end else begin
                cycle($urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 1) == 1, int'($urandom_range(0, MOD - 1)),
                      $urandom_range(0, 1) == 1);
            end
            compared++;
            if (SYSTEM_MEM_OUT !== model_mem[N-1:0] || SERIAL_OUT !== model_sout[0]) begin
                mismatched++;
                $display("FAIL random[%0d]: got mem=%b sout=%b expected mem=%b sout=%b",
                         i, SYSTEM_MEM_OUT, SERIAL_OUT, model_mem[N-1:0], model_sout[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold_after_reset();
        test_load();
        test_run_hold_reset();
        test_output_rotation();
        test_precedence();
        test_reset_mid_output();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
